// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Optional MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module mdu_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        ready,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] opb_q, opb_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] trial;
    logic        take;
    logic [31:0] trial_sub;
    logic        mul_last;

    assign signed_op = ~op[0];
    assign sign_a    = signed_op & da[31];
    assign sign_b    = signed_op & db[31];
    assign mag_a     = sign_a ? (32'd0 - da) : da;
    assign mag_b     = sign_b ? (32'd0 - db) : db;

    // Restoring step: acc holds {partial remainder, dividend bits still to shift in}.
    assign trial     = acc_q[63:31];
    assign take      = (trial >= {1'b0, opb_q});
    assign trial_sub = trial[31:0] - opb_q;

`ifdef MDU_EARLY_OUT_EN
    assign mul_last  = (cnt_q == 6'd31) || (opb_q[31:1] == 31'd0);
`else
    assign mul_last  = (cnt_q == 6'd31);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        ready_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_hi) hi_d = wd;
                if (wr_lo) lo_d = wd;
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    opb_d = mag_b;
                    if (op[1]) begin
                        mcand_d  = '0;
                        acc_d    = {32'd0, mag_a};
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = sign_a;
                        state_d  = ST_CALC;
                        if (db == 32'd0) begin
                            acc_d    = {da, 32'hFFFF_FFFF};
                            neg_lo_d = 1'b0;
                            neg_hi_d = 1'b0;
                            state_d  = ST_FIX;
                        end
                    end else begin
                        mcand_d  = {32'd0, mag_a};
                        acc_d    = '0;
                        neg_lo_d = sign_a ^ sign_b;
                        neg_hi_d = sign_a ^ sign_b;
                        state_d  = ST_CALC;
`ifdef MDU_EARLY_OUT_EN
                        if (mag_b == 32'd0) state_d = ST_FIX;
`endif
                    end
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (op_q[1]) begin
                    if (take) acc_d = {trial_sub, acc_q[30:0], 1'b1};
                    else      acc_d = {trial[31:0], acc_q[30:0], 1'b0};
                    if (cnt_q == 6'd31) state_d = ST_FIX;
                end else begin
                    if (opb_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = {mcand_q[62:0], 1'b0};
                    opb_d   = {1'b0, opb_q[31:1]};
                    if (mul_last) state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (op_q[1]) begin
                    if (neg_hi_q) acc_d[63:32] = 32'd0 - acc_q[63:32];
                    if (neg_lo_q) acc_d[31:0]  = 32'd0 - acc_q[31:0];
                end else if (neg_lo_q) begin
                    acc_d = 64'd0 - acc_q;
                end
                state_d = ST_DONE;
            end

            default: begin
                hi_d    = acc_q[63:32];
                lo_d    = acc_q[31:0];
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
